// File: rtl/scarv_soc_bram_port_ctrl.sv
// scarv_soc_bram_port_ctrl: bus-to-BRAM port controller with range/protection checks and response buffering
module scarv_soc_bram_port_ctrl #(
    parameter logic [31:0] BASE     = 32'h0000_0000,
    parameter int          DEPTH    = 1024,
    parameter bit          WRITE_EN = 1'b1,
    localparam int         LW       = $clog2(DEPTH)
) (
    input  logic          g_clk,
    input  logic          g_reset,
    input  logic          mem_req,
    output logic          mem_gnt,
    input  logic          mem_wen,
    input  logic [3:0]    mem_strb,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    output logic          mem_recv,
    input  logic          mem_ack,
    output logic          mem_error,
    output logic [31:0]   mem_rdata,
    output logic          bram_en,
    output logic [3:0]    bram_we,
    output logic [LW-1:0] bram_addr,
    output logic [31:0]   bram_din,
    input  logic [31:0]   bram_dout
);

    typedef enum logic [1:0] {IDLE, LIVE, HOLD, ERR} state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic        slot_free, req_err;

    always_comb begin
        req_err   = (mem_addr[31:LW] != BASE[31:LW]) || (mem_addr[1:0] != 2'b00) || (mem_wen && !WRITE_EN);
        slot_free = (state_q == IDLE) || mem_ack;
        mem_gnt   = mem_req && slot_free && !g_reset;
        bram_en   = mem_gnt && !req_err;
        bram_we   = (bram_en && mem_wen) ? mem_strb : 4'b0000;
        bram_addr = mem_addr[LW-1:0];
        bram_din  = mem_wdata;
        mem_recv  = state_q != IDLE;
        mem_error = state_q == ERR;
        mem_rdata = (state_q == LIVE) ? bram_dout : (state_q == HOLD) ? hold_q : 32'h0;
        // LIVE data comes straight from the BRAM and must be captured before the port is reused
        hold_d    = (state_q == LIVE && !mem_ack) ? bram_dout : hold_q;
        state_d   = state_q;
        if (slot_free)
            state_d = !mem_gnt ? IDLE : req_err ? ERR : LIVE;
        else if (state_q == LIVE)
            state_d = HOLD;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= IDLE;
            hold_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_scarv_soc_bram_port_ctrl.sv
// tb_scarv_soc_bram_port_ctrl: vector table plus hand sequences against a behavioural BRAM model
module tb_scarv_soc_bram_port_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, wen = 1'b0, ack = 1'b1;
    logic [3:0]  strb = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        gnt, recv, err, en;
    logic [3:0]  we;
    logic [9:0]  baddr;
    logic [31:0] rdata, din;
    logic [31:0] dout = 32'h0;
    logic        rom_gnt, rom_recv, rom_err, rom_en;
    logic [3:0]  rom_we;
    logic [9:0]  rom_baddr;
    logic [31:0] rom_rdata, rom_din;
    logic [31:0] ram [256];
    logic        preload = 1'b1, rand_dout = 1'b0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    scarv_soc_bram_port_ctrl #(.BASE(32'h1000), .DEPTH(1024), .WRITE_EN(1'b1)) u_dut (
        .g_clk(clk), .g_reset(rst), .mem_req(req), .mem_gnt(gnt), .mem_wen(wen), .mem_strb(strb),
        .mem_addr(addr), .mem_wdata(wdata), .mem_recv(recv), .mem_ack(ack), .mem_error(err),
        .mem_rdata(rdata), .bram_en(en), .bram_we(we), .bram_addr(baddr), .bram_din(din), .bram_dout(dout)
    );

    scarv_soc_bram_port_ctrl #(.BASE(32'h1000), .DEPTH(1024), .WRITE_EN(1'b0)) u_rom (
        .g_clk(clk), .g_reset(rst), .mem_req(req), .mem_gnt(rom_gnt), .mem_wen(wen), .mem_strb(strb),
        .mem_addr(addr), .mem_wdata(wdata), .mem_recv(rom_recv), .mem_ack(ack), .mem_error(rom_err),
        .mem_rdata(rom_rdata), .bram_en(rom_en), .bram_we(rom_we), .bram_addr(rom_baddr), .bram_din(rom_din),
        .bram_dout(32'hFFFF_FFFF)
    );

    always @(posedge clk) begin
        if (preload) begin
            ram[4]  <= 32'hDEAD_BEEF;
            ram[8]  <= 32'h1122_3344;
            ram[12] <= 32'h1234_5678;
            for (int i = 0; i < 8; i++) ram[16+i] <= 32'hA000_0000 + 32'(i);
        end else if (en) begin
            for (int b = 0; b < 4; b++)
                if (we[b]) ram[baddr[9:2]][8*b +: 8] <= din[8*b +: 8];
            dout <= ram[baddr[9:2]];
        end else if (rand_dout)
            dout <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, input logic k);
        @(negedge clk);
        req = r; wen = w; strb = s; addr = a; wdata = d; ack = k;
        #1;
    endtask

    typedef struct {
        logic        r, w;
        logic [3:0]  s;
        logic [31:0] a, d;
        logic        k;
        logic        e_gnt, e_en;
        logic [3:0]  e_we;
        logic [9:0]  e_addr;
        logic        e_recv, e_err, c_rdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vt [10];

    initial begin
        vt[0] = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,         1'b1, 1'b0, 1'b0, 4'h0, 10'h0,  1'b0, 1'b0, 1'b1, 32'h0};
        vt[1] = '{1'b1, 1'b0, 4'h0, 32'h1010, 32'h0,         1'b1, 1'b1, 1'b1, 4'h0, 10'h10, 1'b0, 1'b0, 1'b1, 32'h0};
        vt[2] = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,         1'b1, 1'b0, 1'b0, 4'h0, 10'h0,  1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vt[3] = '{1'b1, 1'b1, 4'h3, 32'h1020, 32'hAABB_CCDD, 1'b1, 1'b1, 1'b1, 4'h3, 10'h20, 1'b0, 1'b0, 1'b1, 32'h0};
        vt[4] = '{1'b1, 1'b0, 4'h0, 32'h1020, 32'h0,         1'b1, 1'b1, 1'b1, 4'h0, 10'h20, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[5] = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,         1'b1, 1'b0, 1'b0, 4'h0, 10'h0,  1'b1, 1'b0, 1'b1, 32'h1122_CCDD};
        vt[6] = '{1'b1, 1'b0, 4'h0, 32'h2000, 32'h0,         1'b1, 1'b1, 1'b0, 4'h0, 10'h0,  1'b0, 1'b0, 1'b1, 32'h0};
        vt[7] = '{1'b1, 1'b0, 4'h0, 32'h1002, 32'h0,         1'b1, 1'b1, 1'b0, 4'h0, 10'h0,  1'b1, 1'b1, 1'b1, 32'h0};
        vt[8] = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,         1'b1, 1'b0, 1'b0, 4'h0, 10'h0,  1'b1, 1'b1, 1'b1, 32'h0};
        vt[9] = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,         1'b1, 1'b0, 1'b0, 4'h0, 10'h0,  1'b0, 1'b0, 1'b1, 32'h0};

        drive(1'b1, 1'b0, 4'h0, 32'h1010, 32'h0, 1'b1);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_en", 32'(en), 32'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("rst_recv", 32'(recv), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0; preload = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].r, vt[i].w, vt[i].s, vt[i].a, vt[i].d, vt[i].k);
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vt[i].e_gnt));
            chk($sformatf("v%0d_en", i), 32'(en), 32'(vt[i].e_en));
            chk($sformatf("v%0d_we", i), 32'(we), 32'(vt[i].e_we));
            if (vt[i].e_en) chk($sformatf("v%0d_addr", i), 32'(baddr), 32'(vt[i].e_addr));
            chk($sformatf("v%0d_recv", i), 32'(recv), 32'(vt[i].e_recv));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].e_err));
            if (vt[i].c_rdata) chk($sformatf("v%0d_rdata", i), rdata, vt[i].e_rdata);
        end

        // read-only instance: write request is rejected without touching its BRAM port
        drive(1'b1, 1'b1, 4'hF, 32'h1024, 32'h5555_5555, 1'b1);
        chk("rom_gnt", 32'(rom_gnt), 32'h1);
        chk("rom_en", 32'(rom_en), 32'h0);
        chk("rom_we", 32'(rom_we), 32'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("rom_recv", 32'(rom_recv), 32'h1);
        chk("rom_err", 32'(rom_err), 32'h1);
        chk("rom_rdata", rom_rdata, 32'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("rom_idle", 32'(rom_recv), 32'h0);

        // back-pressure with a scrambled BRAM output
        drive(1'b1, 1'b0, 4'h0, 32'h1030, 32'h0, 1'b1);
        chk("bp_gnt0", 32'(gnt), 32'h1);
        rand_dout = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 4'h0, 32'h1010, 32'h0, 1'b0);
            chk($sformatf("bp%0d_gnt", c), 32'(gnt), 32'h0);
            chk($sformatf("bp%0d_en", c), 32'(en), 32'h0);
            chk($sformatf("bp%0d_recv", c), 32'(recv), 32'h1);
            chk($sformatf("bp%0d_rdata", c), rdata, 32'h1234_5678);
        end
        drive(1'b1, 1'b0, 4'h0, 32'h1010, 32'h0, 1'b1);
        chk("bp_ack_gnt", 32'(gnt), 32'h1);
        chk("bp_ack_en", 32'(en), 32'h1);
        chk("bp_ack_rdata", rdata, 32'h1234_5678);
        rand_dout = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("bp_next_rdata", rdata, 32'hDEAD_BEEF);

        // streaming
        for (int i = 0; i < 9; i++) begin
            drive(i < 8, 1'b0, 4'h0, 32'h1040 + 32'(4*i), 32'h0, 1'b1);
            if (i < 8) chk($sformatf("st%0d_gnt", i), 32'(gnt), 32'h1);
            chk($sformatf("st%0d_recv", i), 32'(recv), 32'(i > 0));
            if (i > 0) chk($sformatf("st%0d_rdata", i), rdata, 32'hA000_0000 + 32'(i-1));
        end

        // reset while holding a response, with a write offered in the reset cycle
        drive(1'b1, 1'b0, 4'h0, 32'h1030, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 4'hF, 32'h1030, 32'h0BAD_0BAD, 1'b0);
        chk("rm_hold_recv", 32'(recv), 32'h1);
        chk("rm_hold_rdata", rdata, 32'h1234_5678);
        rst = 1'b1;
        #1;
        chk("rm_gnt", 32'(gnt), 32'h0);
        chk("rm_en", 32'(en), 32'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        rst = 1'b0;
        #1;
        chk("rm_recv", 32'(recv), 32'h0);
        chk("rm_ram", ram[12], 32'h1234_5678);
        req = 1'b1; addr = 32'h1030;
        #1;
        chk("rm_gnt_after", 32'(gnt), 32'h1);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("rm_read_back", rdata, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scarv_soc_bram_port_ctrl.md
# scarv_soc_bram_port_ctrl

Single-port bus-to-BRAM controller: accepts requests on the SoC memory request/response bus and drives one port of the dual-port BRAM (`scarv_soc_bram_dual`). It sits directly upstream of that BRAM, one instance per BRAM port (CPU instruction side on port A, data/interconnect side on port B). It handles:
- address range checking and write protection;
- the BRAM's one-cycle read latency;
- buffering a response the bus master is not yet ready to accept.

## Interface
Parameters:
- `BASE`, `32'h0000_0000`: byte address of BRAM offset 0; must be `DEPTH`-aligned.
- `DEPTH`, `1024`: BRAM size in bytes, power of two, ≥ 4. `LW = $clog2(DEPTH)`.
- `WRITE_EN`, `1`: 0 makes the region read-only (ROM).

Ports:
- `g_clk` in 1: clock; all state updates on rising edge.
- `g_reset` in 1: synchronous, active-high reset.
- `mem_req` in 1: request valid.
- `mem_gnt` out 1: request accepted this cycle (transfer = `mem_req & mem_gnt`).
- `mem_wen` in 1: 1 = write, 0 = read.
- `mem_strb` in 4: byte write strobes.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_recv` out 1: response valid.
- `mem_ack` in 1: response accepted by master (transfer = `mem_recv & mem_ack`).
- `mem_error` out 1: response carries an error.
- `mem_rdata` out 32: read data.
- `bram_en` out 1: BRAM port enable.
- `bram_we` out 4: BRAM byte write enables.
- `bram_addr` out LW: BRAM byte address.
- `bram_din` out 32: BRAM write data.
- `bram_dout` in 32: BRAM read data, valid the cycle after `bram_en`, held stable while `bram_en` is low.

## Operation
- Request classification (combinational on `mem_addr`):
  - **in range:** `mem_addr[31:LW] == BASE[31:LW]`.
  - **error request:** not in range, or `mem_addr[1:0] != 0`, or (`mem_wen` and `WRITE_EN == 0`).
- Response slot: one response outstanding at most. The slot is free when `mem_recv == 0`, or when `mem_recv & mem_ack` this cycle.
- `mem_gnt = mem_req & slot_free`. The grant is combinational; there is no bubble between back-to-back requests.
- BRAM drive on an accepted, non-error request:
  - `bram_en = 1`;
  - `bram_we = mem_wen ? mem_strb : 4'b0`;
  - `bram_addr = mem_addr[LW-1:0]`;
  - `bram_din = mem_wdata`.
- On an accepted error request: `bram_en = 0`, `bram_we = 0`. The BRAM is never touched.
- `bram_en` is never high unless `mem_gnt` is high. `bram_addr` and `bram_din` are don't-care when `bram_en = 0`, but are driven from the bus (no X).
- State machine (2 bits):
  - **IDLE:** `mem_recv = 0`.
    - Accept non-error → LIVE.
    - Accept error → ERR.
  - **LIVE:** `mem_recv = 1`, `mem_error = 0`, `mem_rdata = bram_dout` (writes also return `bram_dout`; masters ignore it).
    - If `mem_ack`: go to LIVE, ERR or IDLE per that cycle's new accept (or no accept).
    - Else: capture `bram_dout` into `hold_q` → HOLD.
  - **HOLD:** `mem_recv = 1`, `mem_error = 0`, `mem_rdata = hold_q`.
    - On `mem_ack`: next state per that cycle's accept, as in LIVE.
  - **ERR:** `mem_recv = 1`, `mem_error = 1`, `mem_rdata = 0`.
    - Remain until `mem_ack`; then next state per that cycle's accept.
- HOLD exists because `bram_dout` is only guaranteed stable while `bram_en` stays low. Capturing into `hold_q` keeps the response independent of BRAM behaviour.
- Reset:
  - State → IDLE; `hold_q` → 0.
  - Outputs after reset: `mem_recv = 0`, `mem_error = 0`, `mem_rdata = 0`, `bram_en = 0`, `bram_we = 0`, `mem_gnt = mem_req`.
  - Reset mid-operation drops any pending response silently. A BRAM write granted in the reset cycle is not issued: `bram_en` is gated by `!g_reset`, and `mem_gnt` is 0 while `g_reset` is high.

## Timing
- Read latency: request accepted in cycle N → `mem_recv` high in cycle N+1, with data.
- Write latency: write is committed at the end of cycle N; response in N+1.
- Throughput: one request per cycle while `mem_ack` is held high.
- Simultaneous ack and accept in the same cycle: the new response appears next cycle, with no gap.
- Back-pressure: `mem_recv`, `mem_error` and `mem_rdata` stay stable from the first cycle of the response until the ack cycle inclusive.
- Read-after-write to the same address in consecutive accepted requests returns the newly written data. This follows from BRAM ordering and needs no forwarding logic.
- `mem_gnt` depends combinationally on `mem_req` and `mem_ack`. There is no combinational path from `mem_addr` to `mem_gnt`.

## Test plan
- **Read hit:** `BASE=0x1000`, `DEPTH=1024`; BRAM word 0x10 = `0xDEADBEEF`; read `0x1010`, `mem_ack` held high → `bram_en` pulse with `bram_addr = 0x010`; next cycle `mem_recv = 1`, `mem_rdata = 0xDEADBEEF`, `mem_error = 0`.
- **Write then read:** write `0x1020`, strb `4'b0011`, data `0xAABBCCDD` over `0x11223344` → `bram_we = 4'b0011`; following read returns `0x1122CCDD`.
- **Errors:** read `0x2000` (out of range), read `0x1002` (misaligned), and write with `WRITE_EN = 0` → `bram_en` never asserted; each gives one response with `mem_error = 1`, `mem_rdata = 0`.
- **Back-pressure:** read returning `0x12345678` with `mem_ack = 0` for 3 cycles, while the BRAM model randomises `bram_dout` → `mem_rdata` stays `0x12345678`; `mem_gnt = 0` throughout; ack in cycle 4 with a new `mem_req` → `mem_gnt = 1` that cycle.
- **Streaming:** 8 back-to-back reads with `mem_ack` tied high → 8 grants in 8 consecutive cycles, responses in order with 1-cycle offset.
- **Reset mid-operation:** assert `g_reset` during HOLD with a concurrent write request → next cycle `mem_recv = 0`, BRAM contents unchanged, state IDLE.
